// File: rtl/core_irq_pkg.sv
// Shared types and width helpers for the interrupt controller.
// Pure declarations: no logic, no timing.
package core_irq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2,
        HOLDOFF  = 2'd3
    } irq_state_e;

    // irq_id is at least one bit wide even for a single source
    function automatic int irq_id_w(input int num_irq);
        return (num_irq > 1) ? $clog2(num_irq) : 1;
    endfunction

    function automatic int tmo_w(input int ack_timeout);
        return $clog2(ack_timeout + 1);
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Synchronises one asynchronous interrupt pin and flags its rising edge.
// Latency: rise is high for one cycle, SYNC_STAGES cycles after the pin goes high; no backpressure.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic src,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], src};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/core_irq_ctrl.sv
// Interrupt controller: pending/overflow latches, lowest-index priority, request FSM with ack timeout.
// Latency: interrupt rises one cycle after an eligible source is seen in IDLE; held until core_ack or timeout.
// Build option: define CORE_IRQ_IDLE_GATE_EN to raise requests only while core_idle is high.
module core_irq_ctrl
    import core_irq_pkg::*;
#(
    parameter int NUM_IRQ     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_IRQ-1:0]               irq_src,
    input  logic [NUM_IRQ-1:0]               irq_mask,
    input  logic                             core_idle,
    input  logic                             core_ack,
    output logic                             interrupt,
    output logic [irq_id_w(NUM_IRQ)-1:0]     irq_id,
    output logic [NUM_IRQ-1:0]               irq_pending,
    output logic [NUM_IRQ-1:0]               irq_ovf,
    output logic                             ack_tmo
);

    localparam int IRQ_ID_W = irq_id_w(NUM_IRQ);
    localparam int TMO_W    = tmo_w(ACK_TIMEOUT);

    irq_state_e             state, state_nxt;
    logic [NUM_IRQ-1:0]     rise_vec;
    logic [NUM_IRQ-1:0]     clr_vec;
    logic [NUM_IRQ-1:0]     eligible;
    logic [IRQ_ID_W-1:0]    pri_id;
    logic                   pri_vld;
    logic                   start;
    logic                   tmo_hit;
    logic                   int_nxt;
    logic                   tmo_set;
    logic [TMO_W-1:0]       tmo_cnt;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .reset (reset),
            .src   (irq_src[g]),
            .rise  (rise_vec[g])
        );
    end

    assign eligible = irq_pending & irq_mask;

    // Descending scan so the lowest set index is the last assignment
    always_comb begin
        pri_id  = '0;
        pri_vld = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                pri_id  = IRQ_ID_W'(i);
                pri_vld = 1'b1;
            end
        end
    end

`ifdef CORE_IRQ_IDLE_GATE_EN
    assign start = pri_vld & core_idle;
`else
    logic unused_core_idle;
    assign unused_core_idle = core_idle;
    assign start = pri_vld;
`endif

    assign tmo_hit = (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = REQ;
            REQ:      state_nxt = WAIT_ACK;
            WAIT_ACK: if (core_ack || tmo_hit) state_nxt = HOLDOFF;
            HOLDOFF:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        int_nxt = (state_nxt == REQ) || (state_nxt == WAIT_ACK);
        tmo_set = (state == WAIT_ACK) && !core_ack && tmo_hit;
        clr_vec = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr_vec[i] = (state == WAIT_ACK) && core_ack && (irq_id == IRQ_ID_W'(i));
        end
    end

    // A fresh edge coinciding with the ack re-arms the source rather than counting as overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            interrupt   <= 1'b0;
            irq_id      <= '0;
            irq_pending <= '0;
            irq_ovf     <= '0;
            ack_tmo     <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            interrupt   <= int_nxt;
            irq_pending <= (irq_pending & ~clr_vec) | rise_vec;
            irq_ovf     <= irq_ovf | (rise_vec & irq_pending & ~clr_vec);
            ack_tmo     <= ack_tmo | tmo_set;
            if (state == IDLE && start)
                irq_id <= pri_id;
            if (state == REQ)
                tmo_cnt <= '0;
            else if (state == WAIT_ACK && tmo_cnt != TMO_W'(ACK_TIMEOUT))
                tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

endmodule

// File: tb/tb_core_irq_ctrl.sv
// Scoreboard bench for core_irq_ctrl (NUM_IRQ=4, SYNC_STAGES=2, ACK_TIMEOUT=8).
// Stimulus queues each expected request; a monitor checks every interrupt assertion against it.
module tb_core_irq_ctrl;

    typedef struct {
        int id;
        int len;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] irq_src;
    logic [3:0] irq_mask;
    logic       core_idle;
    logic       core_ack;
    logic       interrupt;
    logic [1:0] irq_id;
    logic [3:0] irq_pending;
    logic [3:0] irq_ovf;
    logic       ack_tmo;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    core_irq_ctrl #(.NUM_IRQ(4), .SYNC_STAGES(2), .ACK_TIMEOUT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .irq_src     (irq_src),
        .irq_mask    (irq_mask),
        .core_idle   (core_idle),
        .core_ack    (core_ack),
        .interrupt   (interrupt),
        .irq_id      (irq_id),
        .irq_pending (irq_pending),
        .irq_ovf     (irq_ovf),
        .ack_tmo     (ack_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int id, input int len);
        exp_t e;
        e.id  = id;
        e.len = len;
        sb.push_back(e);
    endtask

    task automatic pulse_src(input logic [3:0] bits);
        irq_src = irq_src | bits;
        tick(2);
        irq_src = irq_src & ~bits;
    endtask

    task automatic wait_int(input string name);
        int n = 0;
        while (!interrupt && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(interrupt), 32'd1);
    endtask

    task automatic wait_low(input string name);
        int n = 0;
        while (interrupt && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(interrupt), 32'd0);
    endtask

    task automatic do_ack();
        core_ack = 1'b1;
        tick(1);
        core_ack = 1'b0;
    endtask

    // Monitor: every rising interrupt must match the head of the scoreboard
    bit   m_prev   = 1'b0;
    bit   m_have   = 1'b0;
    bit   m_fallen = 1'b0;
    int   m_hi     = 0;
    int   m_lo     = 0;
    exp_t m_cur;

    initial begin
        forever begin
            @(negedge clk);
            if (interrupt && !m_prev) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    m_have = 1'b0;
                    $display("FAIL unexpected_req: got irq_id=%0d, expected no request", irq_id);
                end else begin
                    m_cur  = sb.pop_front();
                    m_have = 1'b1;
                end
                if (m_fallen) chk("low_gap_ge1", 32'(m_lo >= 1), 32'd1);
                m_hi = 0;
            end
            if (interrupt) begin
                m_hi++;
                if (m_have) chk("irq_id", 32'(irq_id), 32'(m_cur.id));
            end
            if (!interrupt && m_prev) begin
                m_fallen = 1'b1;
                m_lo     = 0;
                if (m_have && m_cur.len != 0) chk("high_len", 32'(m_hi), 32'(m_cur.len));
                m_have = 1'b0;
            end
            if (!interrupt) m_lo++;
            m_prev = interrupt;
        end
    end

    initial begin
        reset     = 1'b0;
        irq_src   = '0;
        irq_mask  = 4'hF;
        core_idle = 1'b1;
        core_ack  = 1'b0;
        tick(3);
        chk("rst_interrupt", 32'(interrupt), 32'd0);
        chk("rst_irq_id", 32'(irq_id), 32'd0);
        chk("rst_pending", 32'(irq_pending), 32'd0);
        chk("rst_ovf", 32'(irq_ovf), 32'd0);
        chk("rst_ack_tmo", 32'(ack_tmo), 32'd0);
        reset = 1'b1;
        tick(2);

        // Single source served and acknowledged
        push(2, 0);
        pulse_src(4'b0100);
        wait_int("t1_req");
        chk("t1_pending", 32'(irq_pending), 32'h4);
        tick(2);
        do_ack();
        chk("t1_pending_clr", 32'(irq_pending), 32'h0);
        chk("t1_int_low", 32'(interrupt), 32'd0);
        tick(3);

        // Simultaneous edges: lowest index first
        push(1, 0);
        push(3, 0);
        pulse_src(4'b1010);
        wait_int("t2_req1");
        chk("t2_pending", 32'(irq_pending), 32'hA);
        tick(2);
        do_ack();
        chk("t2_pending_after1", 32'(irq_pending), 32'h8);
        wait_int("t2_req3");
        tick(2);
        do_ack();
        chk("t2_pending_after3", 32'(irq_pending), 32'h0);
        tick(3);

        // Masked source latches but does not request until unmasked
        irq_mask = 4'b1110;
        pulse_src(4'b0001);
        tick(6);
        chk("t3_pending_masked", 32'(irq_pending), 32'h1);
        chk("t3_no_int", 32'(interrupt), 32'd0);
        push(0, 0);
        irq_mask = 4'hF;
        wait_int("t3_req0");
        tick(2);
        do_ack();
        chk("t3_pending_clr", 32'(irq_pending), 32'h0);
        tick(3);

        // Timeout: REQ cycle + 8 WAIT_ACK cycles high, then re-request
        push(2, 9);
        push(2, 0);
        pulse_src(4'b0100);
        wait_int("t4_req");
        wait_low("t4_drop");
        chk("t4_ack_tmo", 32'(ack_tmo), 32'd1);
        chk("t4_pending_kept", 32'(irq_pending), 32'h4);
        wait_int("t4_rereq");
        tick(2);
        do_ack();
        chk("t4_pending_clr", 32'(irq_pending), 32'h0);
        tick(3);

        // New edge coinciding with ack keeps pending set without overflow
        push(2, 0);
        pulse_src(4'b0100);
        wait_int("t5_req");
        tick(2);
        irq_src[2] = 1'b1;
        tick(2);
        do_ack();
        chk("t5_pending_kept", 32'(irq_pending), 32'h4);
        chk("t5_no_ovf", 32'(irq_ovf), 32'h0);
        chk("t5_int_low", 32'(interrupt), 32'd0);
        irq_src[2] = 1'b0;
        push(2, 0);
        wait_int("t5_rereq");
        tick(2);
        do_ack();
        tick(3);

        // Overflow: second edge while already pending
        irq_mask = 4'b1011;
        pulse_src(4'b0100);
        tick(4);
        pulse_src(4'b0100);
        tick(4);
        chk("t5_ovf", 32'(irq_ovf), 32'h4);
        chk("t5_pending_ovf", 32'(irq_pending), 32'h4);
        push(2, 0);
        irq_mask = 4'hF;
        wait_int("t5_req_ovf");
        tick(2);
        do_ack();
        chk("t5_ovf_sticky", 32'(irq_ovf), 32'h4);
        tick(3);

        // Idle gating (when built in), then reset during WAIT_ACK
        core_idle = 1'b0;
`ifdef CORE_IRQ_IDLE_GATE_EN
        pulse_src(4'b0010);
        tick(8);
        chk("t6_gated", 32'(interrupt), 32'd0);
        push(1, 0);
        core_idle = 1'b1;
        tick(1);
        chk("t6_ungated", 32'(interrupt), 32'd1);
`else
        push(1, 0);
        pulse_src(4'b0010);
        wait_int("t6_idle_ignored");
`endif
        tick(1);
        reset = 1'b0;
        #1;
        chk("t6_rst_interrupt", 32'(interrupt), 32'd0);
        chk("t6_rst_irq_id", 32'(irq_id), 32'd0);
        chk("t6_rst_pending", 32'(irq_pending), 32'h0);
        chk("t6_rst_ovf", 32'(irq_ovf), 32'h0);
        chk("t6_rst_ack_tmo", 32'(ack_tmo), 32'd0);
        tick(2);
        reset     = 1'b1;
        core_idle = 1'b1;
        tick(4);
        chk("t6_post_rst_int", 32'(interrupt), 32'd0);
        chk("t6_post_rst_pending", 32'(irq_pending), 32'h0);

        tick(5);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
